// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares the single byte-wide RAM port between the icache line refill (IF)
//   and the load/store buffer (LS). Every multi-byte transfer is serialised
//   one byte per clock, little-endian. Speculative reads are dropped when the
//   ROB signals a rollback. Committed stores always run to completion.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   i_rdy               global ready; when low, every register holds
//   i_rollback          ROB branch-wrong; aborts reads, blocks new grants
//   i_io_buffer_full    UART output buffer full (used only by the IO guard)
//   i_if_req/i_if_addr  icache refill request (level) and line base address
//   o_if_done/o_if_data one-cycle done pulse and refill line (byte k at [8k+:8])
//   i_ls_req/_wr/_size  LS request (level), store flag, size (0 B, 1 H, 2/3 W)
//   i_ls_addr/_wdata    LS access address and store data
//   o_ls_done/_rdata    one-cycle done pulse and zero-extended load data
//   i_mem_din           RAM read data, for the address driven one cycle earlier
//   o_mem_dout/_a/_wr   RAM write data, address and write strobe
//
// Configuration:
//   MEM_ARB_IO_GUARD_EN  When defined, a store beat that targets IO space
//                        (address >= IO_BASE) waits while i_io_buffer_full=1.
//                        When undefined, i_io_buffer_full is ignored.
//
// States:
//   S_IDLE  | no transfer; arbitrates a new request on this edge
//   S_IF_RD | icache line refill in progress
//   S_LS_RD | LS load in progress
//   S_LS_WR | LS store in progress
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int          LINE_BYTES = 16,
    parameter logic [31:0] IO_BASE    = 32'h30000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_rdy,
    input  logic                    i_rollback,
    input  logic                    i_io_buffer_full,
    input  logic                    i_if_req,
    input  logic [31:0]             i_if_addr,
    output logic                    o_if_done,
    output logic [8*LINE_BYTES-1:0] o_if_data,
    input  logic                    i_ls_req,
    input  logic                    i_ls_wr,
    input  logic [1:0]              i_ls_size,
    input  logic [31:0]             i_ls_addr,
    input  logic [31:0]             i_ls_wdata,
    output logic                    o_ls_done,
    output logic [31:0]             o_ls_rdata,
    input  logic [7:0]              i_mem_din,
    output logic [7:0]              o_mem_dout,
    output logic [31:0]             o_mem_a,
    output logic                    o_mem_wr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IF_RD = 2'd1,
        S_LS_RD = 2'd2,
        S_LS_WR = 2'd3
    } state_t;

    // Beat counter must hold LINE_BYTES itself (up to 64).
    localparam int            CW   = 7;
    localparam int            LW   = $clog2(8*LINE_BYTES);
    localparam logic [CW-1:0] IF_N = CW'(LINE_BYTES);

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           r_n;
    logic [31:0]             r_addr;
    logic [31:0]             r_wdata;
    logic                    r_last_ls;
    logic [8*LINE_BYTES-1:0] r_if_data;
    logic [31:0]             r_ls_rdata;
    logic [31:0]             r_mem_a;
    logic [7:0]              r_mem_dout;
    logic                    r_mem_wr;
    logic                    r_if_done;
    logic                    r_ls_done;

    logic                    w_if_ok;
    logic                    w_ls_ok;
    logic                    w_pick_ls;
    logic [CW-1:0]           w_ls_n;
    logic [CW-1:0]           w_cap_idx;
    logic [LW-1:0]           w_if_bit;
    logic [4:0]              w_ls_bit;
    logic [31:0]             w_beat_a;
    logic [7:0]              w_wr_byte;
    logic                    w_grant_blk;
    logic                    w_beat_blk;

    // A requester whose done pulse is visible this cycle has not yet seen it,
    // so its still-high request must not start a second transfer.
    assign w_if_ok   = i_if_req & ~r_if_done;
    assign w_ls_ok   = i_ls_req & ~r_ls_done;

    // Uncontested requests win outright; on contention the side that was not
    // granted at the previous contention wins.
    assign w_pick_ls = w_ls_ok & (~w_if_ok | ~r_last_ls);

    always_comb begin
        w_ls_n = CW'(4);
        case (i_ls_size)
            2'd0:    w_ls_n = CW'(1);
            2'd1:    w_ls_n = CW'(2);
            default: w_ls_n = CW'(4);
        endcase
    end

    // r_cnt is the beat index k of the current edge. A read captures byte k-1
    // on edge k because RAM data trails the address by one cycle.
    assign w_cap_idx = r_cnt - CW'(1);
    assign w_if_bit  = LW'({w_cap_idx, 3'b000});
    assign w_ls_bit  = {w_cap_idx[1:0], 3'b000};
    assign w_beat_a  = r_addr + 32'(r_cnt);
    assign w_wr_byte = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

`ifdef MEM_ARB_IO_GUARD_EN
    assign w_grant_blk = (i_ls_addr >= IO_BASE) & i_io_buffer_full;
    assign w_beat_blk  = (w_beat_a >= IO_BASE) & i_io_buffer_full;
`else
    logic w_unused_io;
    assign w_unused_io = i_io_buffer_full;
    assign w_grant_blk = 1'b0;
    assign w_beat_blk  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_n        <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_last_ls  <= 1'b1;
            r_if_data  <= '0;
            r_ls_rdata <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
        end else if (i_rdy) begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_mem_wr <= 1'b0;
                    if (!i_rollback && (w_if_ok || w_ls_ok)) begin
                        // Fairness history only moves on a contested grant.
                        if (w_if_ok && w_ls_ok) begin
                            r_last_ls <= w_pick_ls;
                        end
                        if (w_pick_ls) begin
                            r_addr  <= i_ls_addr;
                            r_wdata <= i_ls_wdata;
                            r_n     <= w_ls_n;
                            if (i_ls_wr) begin
                                r_state <= S_LS_WR;
                                // The grant edge is also write beat 0.
                                if (w_grant_blk) begin
                                    r_cnt <= '0;
                                end else begin
                                    r_mem_wr   <= 1'b1;
                                    r_mem_a    <= i_ls_addr;
                                    r_mem_dout <= i_ls_wdata[7:0];
                                    r_cnt      <= CW'(1);
                                end
                            end else begin
                                r_state    <= S_LS_RD;
                                r_mem_a    <= i_ls_addr;
                                r_ls_rdata <= '0;
                                r_cnt      <= CW'(1);
                            end
                        end else begin
                            r_state <= S_IF_RD;
                            r_addr  <= i_if_addr;
                            r_n     <= IF_N;
                            r_mem_a <= i_if_addr;
                            r_cnt   <= CW'(1);
                        end
                    end
                end

                S_IF_RD, S_LS_RD: begin
                    // Rollback wins even on the final capture edge.
                    if (i_rollback) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        if (r_state == S_IF_RD) begin
                            r_if_data[w_if_bit +: 8] <= i_mem_din;
                        end else begin
                            r_ls_rdata[w_ls_bit +: 8] <= i_mem_din;
                        end
                        if (r_cnt == r_n) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                            if (r_state == S_IF_RD) begin
                                r_if_done <= 1'b1;
                            end else begin
                                r_ls_done <= 1'b1;
                            end
                        end else begin
                            r_mem_a <= w_beat_a;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                end

                S_LS_WR: begin
                    if (r_cnt == r_n) begin
                        r_mem_wr  <= 1'b0;
                        r_ls_done <= 1'b1;
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                    end else if (w_beat_blk) begin
                        r_mem_wr <= 1'b0;
                    end else begin
                        r_mem_wr   <= 1'b1;
                        r_mem_a    <= w_beat_a;
                        r_mem_dout <= w_wr_byte;
                        r_cnt      <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign o_if_done  = r_if_done;
    assign o_if_data  = r_if_data;
    assign o_ls_done  = r_ls_done;
    assign o_ls_rdata = r_ls_rdata;
    assign o_mem_dout = r_mem_dout;
    assign o_mem_a    = r_mem_a;
    assign o_mem_wr   = r_mem_wr;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rdy = 1'b1;
    logic          rollback = 1'b0;
    logic          io_full = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          ls_req = 1'b0;
    logic          ls_wr = 1'b0;
    logic [1:0]    ls_size = '0;
    logic [31:0]   ls_addr = '0;
    logic [31:0]   ls_wdata = '0;
    logic          if_done, ls_done, mem_wr;
    logic [8*LB-1:0] if_data;
    logic [31:0]   ls_rdata, mem_a;
    logic [7:0]    mem_dout, mem_din;

    mem_arbiter #(.LINE_BYTES(LB), .IO_BASE(32'h30000)) dut (
        .clk(clk), .rst_n(rst_n), .i_rdy(rdy), .i_rollback(rollback),
        .i_io_buffer_full(io_full),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_done(if_done), .o_if_data(if_data),
        .i_ls_req(ls_req), .i_ls_wr(ls_wr), .i_ls_size(ls_size), .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata), .o_ls_done(ls_done), .o_ls_rdata(ls_rdata),
        .i_mem_din(mem_din), .o_mem_dout(mem_dout), .o_mem_a(mem_a), .o_mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // RAM: 64 KiB aliased over the address space, read data follows mem_a.
    logic [7:0] ram [0:65535];
    assign mem_din = ram[mem_a[15:0]];
    always @(posedge clk) if (mem_wr) ram[mem_a[15:0]] <= mem_dout;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_wr[$];
    logic [7:0] mdl_mem [int];
    logic [31:0] cur_if_addr = '0;
    logic [31:0] cur_ls_addr = '0;
    logic [1:0]  cur_ls_size = '0;
    logic        cur_ls_wr = 1'b0;
    int          wr_seen = 0;
    logic        if_req_q = 1'b0;
    logic        ls_req_q = 1'b0;
    wr_t         e;

    function automatic logic [7:0] mdl_rd(logic [31:0] a);
        int key;
        key = int'(a[15:0]);
        if (mdl_mem.exists(key)) return mdl_mem[key];
        return a[7:0];
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mdl_load(logic [31:0] a, logic [1:0] sz);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < nbytes(sz); k++) r[8*k +: 8] = mdl_rd(a + 32'(k));
        return r;
    endfunction

    function automatic logic [8*LB-1:0] mdl_line(logic [31:0] a);
        logic [8*LB-1:0] r;
        for (int k = 0; k < LB; k++) r[8*k +: 8] = mdl_rd(a + 32'(k));
        return r;
    endfunction

    always @(posedge clk) begin
        if_req_q <= if_req;
        ls_req_q <= ls_req;
    end

    // Compare process: every write beat, every done pulse.
    always @(negedge clk) if (rst_n) begin
        if (mem_wr) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                check("unexpected_wr", 1, 0);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", mem_a, e.a);
                check("wr_data", mem_dout, e.d);
                mdl_mem[int'(e.a[15:0])] = e.d;
            end
        end
        if (if_done) begin
            if (!if_req_q) check("spurious_if_done", 1, 0);
            else check("if_data", if_data, mdl_line(cur_if_addr));
        end
        if (ls_done) begin
            if (!ls_req_q) check("spurious_ls_done", 1, 0);
            else if (!cur_ls_wr) check("ls_rdata", ls_rdata, mdl_load(cur_ls_addr, cur_ls_size));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue_ls(input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] d);
        ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = d; ls_req = 1'b1;
        cur_ls_wr = wr; cur_ls_addr = a; cur_ls_size = sz;
        if (wr) for (int k = 0; k < nbytes(sz); k++) exp_wr.push_back({a + 32'(k), d[8*k +: 8]});
    endtask

    task automatic issue_if(input logic [31:0] a);
        if_addr = a; cur_if_addr = a; if_req = 1'b1;
    endtask

    task automatic wait_ls(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!ls_done && n < 200);
        if (!ls_done) check("ls_done_timeout", 0, 1);
        ls_req = 1'b0;
    endtask

    task automatic wait_if(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!if_done && n < 200);
        if (!if_done) check("if_done_timeout", 0, 1);
        if_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    int n, w0;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i);
        repeat (2) @(negedge clk);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_if_done", if_done, 0);
        check("rst_ls_done", ls_done, 0);
        check("rst_ls_rdata", ls_rdata, 0);
        check("rst_if_data", if_data, 0);
        rst_n = 1'b1;

        // 1: line refill
        @(negedge clk);
        w0 = wr_seen;
        issue_if(32'h1000);
        wait_if(n);
        check("if_latency", n, 17);
        check("if_line_lit", if_data, 128'h0F0E0D0C0B0A09080706050403020100);
        check("if_no_writes", wr_seen - w0, 0);

        // 2: round robin on contention
        apply_reset();
        @(negedge clk);
        issue_if(32'h100);
        issue_ls(1'b0, 2'd0, 32'h55, 32'h0);
        @(negedge clk);
        check("rr1_if_first", mem_a, 32'h100);
        wait_if(n);
        check("rr1_ls_waiting", ls_done, 0);
        wait_ls(n);
        check("rr1_ls_latency", n, 2);
        @(negedge clk);
        issue_if(32'h200);
        issue_ls(1'b0, 2'd0, 32'h77, 32'h0);
        @(negedge clk);
        check("rr2_ls_first", mem_a, 32'h77);
        wait_ls(n);
        wait_if(n);

        // 3: store word, then load half
        @(negedge clk);
        w0 = wr_seen;
        issue_ls(1'b1, 2'd2, 32'h2000, 32'hDEADBEEF);
        wait_ls(n);
        check("st_latency", n, 5);
        check("st_beats", wr_seen - w0, 4);
        @(negedge clk);
        issue_ls(1'b0, 2'd1, 32'h2002, 32'h0);
        wait_ls(n);
        check("ldh_latency", n, 3);
        check("ldh_lit", ls_rdata, 32'h0000DEAD);

        // 4: rollback in refill with store pending; rollback during store
        @(negedge clk);
        issue_if(32'h1000);
        @(negedge clk);
        issue_ls(1'b1, 2'd0, 32'h2100, 32'h5A);
        repeat (4) @(negedge clk);
        rollback = 1'b1; if_req = 1'b0;
        @(negedge clk);
        rollback = 1'b0;
        check("rb_no_if_done", if_done, 0);
        check("rb_idle_no_wr", mem_wr, 0);
        @(negedge clk);
        check("rb_store_granted", mem_wr, 1);
        check("rb_store_addr", mem_a, 32'h2100);
        wait_ls(n);
        @(negedge clk);
        issue_ls(1'b1, 2'd2, 32'h2200, 32'h11223344);
        n = 0;
        do begin @(negedge clk); n++; rollback = (n == 2); end while (!ls_done && n < 50);
        rollback = 1'b0; ls_req = 1'b0;
        check("rb_store_completes", n, 5);
        // rollback on the final capture edge of a byte load
        @(negedge clk);
        issue_ls(1'b0, 2'd0, 32'h2300, 32'h0);
        @(negedge clk);
        rollback = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        rollback = 1'b0;
        check("rb_final_no_done", ls_done, 0);
        @(negedge clk);
        check("rb_final_idle", mem_wr, 0);

        // address wrap
        @(negedge clk);
        issue_ls(1'b0, 2'd1, 32'hFFFFFFFF, 32'h0);
        wait_ls(n);
        check("wrap_latency", n, 3);
        check("wrap_lit", ls_rdata, 32'h000000FF);

        // 5: IO store with buffer full
        @(negedge clk);
        w0 = wr_seen;
        io_full = 1'b1;
        issue_ls(1'b1, 2'd0, 32'h30000, 32'h41);
`ifdef MEM_ARB_IO_GUARD_EN
        repeat (10) @(negedge clk);
        check("io_held", wr_seen - w0, 0);
        io_full = 1'b0;
        wait_ls(n);
        check("io_one_beat", wr_seen - w0, 1);
`else
        @(negedge clk);
        check("io_beat_on_grant", mem_wr, 1);
        check("io_beat_addr", mem_a, 32'h30000);
        wait_ls(n);
        io_full = 1'b0;
        check("io_one_beat", wr_seen - w0, 1);
`endif

        // 6: async reset mid-store, then rdy stall mid-load
        @(negedge clk);
        issue_ls(1'b1, 2'd2, 32'h3000, 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mem_wr", mem_wr, 0);
        check("arst_mem_a", mem_a, 0);
        check("arst_mem_dout", mem_dout, 0);
        exp_wr.delete();
        ls_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle_wr", mem_wr, 0);
        check("arst_idle_a", mem_a, 0);
        issue_ls(1'b0, 2'd2, 32'h2000, 32'h0);
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 2) rdy = 1'b0;
            else if (n >= 3 && n <= 5) begin
                check("frozen_mem_a", mem_a, 32'h2001);
                if (n == 5) rdy = 1'b1;
            end
        end while (!ls_done && n < 50);
        rdy = 1'b1; ls_req = 1'b0;
        check("stall_latency", n, 8);
        check("stall_lit", ls_rdata, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        check("wr_queue_drained", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
